// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port round-robin arbiter sharing one memory port between an
//             instruction-fetch requester and a load/store requester. A grant
//             ends when memory signals ready or when the wait counter runs out.
//             A timed-out grant still acks, but with zero data and err set.
//  Ports    : clk, rst (async, active-low)
//             if_req/if_addr   -> if_rdata/if_ack      fetch requester
//             ls_req/ls_we/ls_addr/ls_wdata -> ls_rdata/ls_ack  load/store
//             mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready  memory
//             err       : pulses with an ack whose access timed out
//             pc_stall  : if_req & ~if_ack (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err,
    output logic        pc_stall
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_LS = 2'd2
    } state_t;

    // The counter holds the number of already-elapsed unready grant cycles, so
    // the abort fires in the cycle where it would step up to MAX_WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_ls;        // 1: load/store port was granted most recently
    logic [7:0] wait_cnt;
    logic       if_elig;
    logic       ls_elig;
    logic       start_if;
    logic       start_ls;
    logic       finish;
    logic       timed_out;

    assign pc_stall = if_req & ~if_ack;

    always_comb begin
        // A port being acked this cycle still shows req high; it must not be
        // re-issued, so the ack masks its request.
        if_elig   = if_req & ~if_ack;
        ls_elig   = ls_req & ~ls_ack;
        start_if  = 1'b0;
        start_ls  = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (if_elig && (!ls_elig || last_ls)) begin
                    start_if  = 1'b1;
                    state_nxt = GRANT_IF;
                end else if (ls_elig) begin
                    start_ls  = 1'b1;
                    state_nxt = GRANT_LS;
                end
            end
            GRANT_IF, GRANT_LS: begin
                timed_out = !mem_ready && (wait_cnt == WAIT_LAST);
                finish    = mem_ready || timed_out;
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ls   <= 1'b1;
            wait_cnt  <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            ls_rdata  <= 32'd0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            ls_ack <= 1'b0;
            err    <= 1'b0;
            if (start_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= 32'd0;
                wait_cnt  <= 8'd0;
            end else if (start_ls) begin
                mem_req   <= 1'b1;
                mem_we    <= ls_we;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
                wait_cnt  <= 8'd0;
            end else if (finish) begin
                mem_req <= 1'b0;
                err     <= timed_out;
                last_ls <= (state == GRANT_LS);
                if (state == GRANT_LS) begin
                    ls_ack   <= 1'b1;
                    ls_rdata <= mem_ready ? mem_rdata : 32'd0;
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= mem_ready ? mem_rdata : 32'd0;
                end
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter (MAX_WAIT = 4): directed
//             scenarios followed by randomized traffic against a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MW = 4;
    localparam logic [31:0] D_RST = 32'hC0DE_0504;
    localparam logic [31:0] D_DRP = 32'hE0E0_0600;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we, mem_ready;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic        if_ack, ls_ack, mem_req, mem_we, err, pc_stall;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err), .pc_stall(pc_stall)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
        if_addr = 32'h1234; ls_addr = 32'h5678; ls_wdata = 32'h9ABC;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) tick;
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0) begin
            errors++; $display("FAIL reset_mem: got req=%0b we=%0b addr=%h wdata=%h expected all 0", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if ({if_ack, ls_ack, err} !== 3'b000) begin
            errors++; $display("FAIL reset_ack: got if_ack=%0b ls_ack=%0b err=%0b expected 0", if_ack, ls_ack, err); end
        checks++; if ({if_rdata, ls_rdata} !== 64'd0) begin
            errors++; $display("FAIL reset_rdata: got %h %h expected 0", if_rdata, ls_rdata); end
        checks++; if (pc_stall !== 1'b1) begin
            errors++; $display("FAIL reset_pc_stall: got %0b expected 1", pc_stall); end
        idle_inputs();
        tick;
    endtask

    task automatic test_single_fetch;
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        #1;
        checks++; if (pc_stall !== 1'b1) begin
            errors++; $display("FAIL fetch_stall_req: got %0b expected 1", pc_stall); end
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL fetch_grant: got req=%0b addr=%h we=%0b wdata=%h expected 1 00000010 0 0", mem_req, mem_addr, mem_we, mem_wdata); end
        checks++; if (if_ack !== 1'b0 || pc_stall !== 1'b1) begin
            errors++; $display("FAIL fetch_early: got if_ack=%0b pc_stall=%0b expected 0 1", if_ack, pc_stall); end
        tick;
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0050_0093 || err !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL fetch_ack: got ack=%0b rdata=%h err=%0b req=%0b expected 1 00500093 0 0", if_ack, if_rdata, err, mem_req); end
        checks++; if (pc_stall !== 1'b0) begin
            errors++; $display("FAIL fetch_stall_ack: got %0b expected 0", pc_stall); end
        tick;
        checks++; if (if_ack !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h0050_0093) begin
            errors++; $display("FAIL fetch_after: got ack=%0b req=%0b rdata=%h expected 0 0 00500093", if_ack, mem_req, if_rdata); end
        idle_inputs();
        tick;
    endtask

    task automatic test_tie;
        rst = 1'b0; tick; tick;
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            errors++; $display("FAIL tie_first: got req=%0b addr=%h expected 1 00000040", mem_req, mem_addr); end
        tick;
        checks++; if (if_ack !== 1'b1 || ls_ack !== 1'b0 || if_rdata !== 32'hA5A5_0001) begin
            errors++; $display("FAIL tie_if_ack: got if_ack=%0b ls_ack=%0b rdata=%h expected 1 0 a5a50001", if_ack, ls_ack, if_rdata); end
        if_req = 1'b0; mem_rdata = 32'hB6B6_0002;
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || ls_ack !== 1'b0) begin
            errors++; $display("FAIL tie_second: got req=%0b addr=%h ls_ack=%0b expected 1 00000200 0", mem_req, mem_addr, ls_ack); end
        tick;
        checks++; if (ls_ack !== 1'b1 || ls_rdata !== 32'hB6B6_0002 || if_rdata !== 32'hA5A5_0001) begin
            errors++; $display("FAIL tie_ls_ack: got ack=%0b ls_rdata=%h if_rdata=%h expected 1 b6b60002 a5a50001", ls_ack, ls_rdata, if_rdata); end
        ls_req = 1'b0;
        tick;
        if_req = 1'b1; if_addr = 32'h44; ls_req = 1'b1; ls_addr = 32'h204; mem_rdata = 32'hC7C7_0003;
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
            errors++; $display("FAIL tie_alternate: got req=%0b addr=%h expected 1 00000044", mem_req, mem_addr); end
        tick;
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hC7C7_0003) begin
            errors++; $display("FAIL tie_alt_ack: got ack=%0b rdata=%h expected 1 c7c70003", if_ack, if_rdata); end
        idle_inputs();
        tick;
    endtask

    task automatic test_store;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
        mem_ready = 1'b0; mem_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 ||
                          mem_wdata !== 32'hDEAD_BEEF || ls_ack !== 1'b0) begin
                errors++; $display("FAIL store_grant%0d: got req=%0b we=%0b addr=%h wdata=%h ack=%0b expected 1 1 00000100 deadbeef 0",
                                   i, mem_req, mem_we, mem_addr, mem_wdata, ls_ack); end
            if (i == 3) mem_ready = 1'b1;
        end
        tick;
        checks++; if (ls_ack !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0 || ls_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL store_ack: got ack=%0b err=%0b req=%0b rdata=%h expected 1 0 0 0badf00d", ls_ack, err, mem_req, ls_rdata); end
        idle_inputs();
        tick;
        checks++; if (ls_ack !== 1'b0) begin
            errors++; $display("FAIL store_pulse: got ls_ack=%0b expected 0", ls_ack); end
    endtask

    task automatic test_timeout;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; mem_ready = 1'b0;
        tick;
        if_req = 1'b1; if_addr = 32'h80;
        checks++; if (mem_addr !== 32'h300) begin
            errors++; $display("FAIL timeout_addr: got %h expected 00000300", mem_addr); end
        for (int i = 0; i < MW; i++) begin
            checks++; if (mem_req !== 1'b1 || ls_ack !== 1'b0 || if_ack !== 1'b0 || err !== 1'b0) begin
                errors++; $display("FAIL timeout_wait%0d: got req=%0b ls_ack=%0b if_ack=%0b err=%0b expected 1 0 0 0",
                                   i, mem_req, ls_ack, if_ack, err); end
            tick;
        end
        checks++; if (ls_ack !== 1'b1 || err !== 1'b1 || ls_rdata !== 32'd0 || mem_req !== 1'b0 || if_ack !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: got ack=%0b err=%0b rdata=%h req=%0b if_ack=%0b expected 1 1 0 0 0",
                               ls_ack, err, ls_rdata, mem_req, if_ack); end
        ls_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hC0C0_0080;
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80 || err !== 1'b0) begin
            errors++; $display("FAIL timeout_next: got req=%0b addr=%h err=%0b expected 1 00000080 0", mem_req, mem_addr, err); end
        tick;
        checks++; if (if_ack !== 1'b1 || err !== 1'b0 || if_rdata !== 32'hC0C0_0080) begin
            errors++; $display("FAIL timeout_if_ack: got ack=%0b err=%0b rdata=%h expected 1 0 c0c00080", if_ack, err, if_rdata); end
        idle_inputs();
        tick;
    endtask

    task automatic test_reset_mid_grant;
        if_req = 1'b1; if_addr = 32'h500; mem_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || if_ack !== 1'b0) begin
            errors++; $display("FAIL midrst_now: got req=%0b ack=%0b expected 0 0", mem_req, if_ack); end
        tick;
        checks++; if (mem_req !== 1'b0 || if_ack !== 1'b0) begin
            errors++; $display("FAIL midrst_hold: got req=%0b ack=%0b expected 0 0", mem_req, if_ack); end
        rst = 1'b1; if_addr = 32'h504; mem_ready = 1'b1; mem_rdata = D_RST;
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h504 || if_ack !== 1'b0) begin
            errors++; $display("FAIL midrst_regrant: got req=%0b addr=%h ack=%0b expected 1 00000504 0", mem_req, mem_addr, if_ack); end
        tick;
        checks++; if (if_ack !== 1'b1 || if_rdata !== D_RST || err !== 1'b0) begin
            errors++; $display("FAIL midrst_ack: got ack=%0b rdata=%h err=%0b expected 1 %h 0", if_ack, if_rdata, err, D_RST); end
        idle_inputs();
        tick;
        checks++; if (if_ack !== 1'b0) begin
            errors++; $display("FAIL midrst_pulse: got ack=%0b expected 0", if_ack); end
    endtask

    task automatic test_drop;
        int acks;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600; mem_ready = 1'b0;
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin
            errors++; $display("FAIL drop_grant: got req=%0b addr=%h expected 1 00000600", mem_req, mem_addr); end
        ls_req = 1'b0;
        tick;
        mem_ready = 1'b1; mem_rdata = D_DRP;
        tick;
        checks++; if (ls_ack !== 1'b1 || ls_rdata !== D_DRP) begin
            errors++; $display("FAIL drop_ack: got ack=%0b rdata=%h expected 1 %h", ls_ack, ls_rdata, D_DRP); end
        mem_ready = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (ls_ack === 1'b1 || mem_req === 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin
            errors++; $display("FAIL drop_no_reissue: got %0d extra cycles with req/ack expected 0", acks); end
    endtask

    // Randomized traffic. Model works per transaction: who wins arbitration,
    // what is latched, how many cycles the memory makes it wait, and the
    // resulting ack/err/data, all from the arbitration and timeout rules.
    task automatic test_random;
        logic        rq[2];
        logic [31:0] ra[2];
        logic [31:0] rw[2];
        logic        rwe;
        logic [31:0] exp_rd[2];
        logic [31:0] exp_addr, exp_wdata;
        logic        exp_we, nerr, busy, e0, e1;
        int          port, waited, delay, last, ack_now, nack;

        rq[0] = 1'b0; rq[1] = 1'b0; ra[0] = 32'd0; ra[1] = 32'd0; rw[0] = 32'd0; rw[1] = 32'd0; rwe = 1'b0;
        exp_rd[0] = D_RST; exp_rd[1] = D_DRP;
        exp_addr = 32'd0; exp_wdata = 32'd0; exp_we = 1'b0;
        busy = 1'b0; port = 0; waited = 0; delay = 0; last = 1; ack_now = -1;
        idle_inputs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nack = -1; nerr = 1'b0;
            if (!busy) begin
                e0 = rq[0] && (ack_now != 0);
                e1 = rq[1] && (ack_now != 1);
                if (e0 || e1) begin
                    port = (e0 && e1) ? (last == 1 ? 0 : 1) : (e0 ? 0 : 1);
                    busy = 1'b1; waited = 0; delay = $urandom_range(5, 0);
                    exp_addr  = ra[port];
                    exp_we    = (port == 1) ? rwe : 1'b0;
                    exp_wdata = (port == 1) ? rw[1] : 32'd0;
                end
            end else begin
                if (mem_ready || waited == MW - 1) begin
                    nack = port; nerr = !mem_ready;
                    exp_rd[port] = mem_ready ? mem_rdata : 32'd0;
                    busy = 1'b0; last = port;
                end else begin
                    waited++;
                end
            end
            ack_now = nack;
            tick;
            checks++; if (mem_req !== busy) begin
                errors++; $display("FAIL rnd_mem_req @%0d: got %0b expected %0b", cyc, mem_req, busy); end
            if (busy) begin
                checks++; if (mem_addr !== exp_addr || mem_we !== exp_we || mem_wdata !== exp_wdata) begin
                    errors++; $display("FAIL rnd_mem_bus @%0d: got %h %0b %h expected %h %0b %h",
                                       cyc, mem_addr, mem_we, mem_wdata, exp_addr, exp_we, exp_wdata); end
            end
            checks++; if (if_ack !== (nack == 0) || ls_ack !== (nack == 1) || err !== nerr) begin
                errors++; $display("FAIL rnd_ack @%0d: got if=%0b ls=%0b err=%0b expected if=%0b ls=%0b err=%0b",
                                   cyc, if_ack, ls_ack, err, nack == 0, nack == 1, nerr); end
            checks++; if (if_rdata !== exp_rd[0] || ls_rdata !== exp_rd[1]) begin
                errors++; $display("FAIL rnd_rdata @%0d: got %h %h expected %h %h", cyc, if_rdata, ls_rdata, exp_rd[0], exp_rd[1]); end
            checks++; if (pc_stall !== (rq[0] && nack != 0)) begin
                errors++; $display("FAIL rnd_pc_stall @%0d: got %0b expected %0b", cyc, pc_stall, rq[0] && nack != 0); end
            for (int p = 0; p < 2; p++) begin
                if (nack == p) begin
                    rq[p] = 1'($urandom_range(1, 0));
                    ra[p] = $urandom; rw[p] = $urandom;
                    if (p == 1) rwe = 1'($urandom_range(1, 0));
                end else if (busy && port == p) begin
                    if ($urandom_range(7, 0) == 0) rq[p] = 1'b0;
                end else if (!rq[p] && $urandom_range(2, 0) == 0) begin
                    rq[p] = 1'b1;
                    ra[p] = $urandom; rw[p] = $urandom;
                    if (p == 1) rwe = 1'($urandom_range(1, 0));
                end
            end
            mem_ready = busy ? (waited == delay) : 1'($urandom_range(1, 0));
            mem_rdata = $urandom;
            if_req = rq[0]; if_addr = ra[0];
            ls_req = rq[1]; ls_addr = ra[1]; ls_wdata = rw[1]; ls_we = rwe;
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie();
        test_store();
        test_timeout();
        test_reset_mid_grant();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
